// File: rtl/noc_traffic_gen_param.sv
// Per-node mesh traffic endpoint: paced multi-flit packet injector on the LOCAL port
// plus an always-ready ejection sink that checks destination and HEAD/BODY/TAIL framing.
module noc_traffic_gen_param #(
  parameter int          XADDR      = 0,
  parameter int          YADDR      = 0,
  parameter int          ROWS       = 4,
  parameter int          COLS       = 4,
  parameter int          FLIT_W     = 32,
  parameter int          PKT_LEN    = 4,
  parameter int          INJ_PERIOD = 16,
  parameter int          PATTERN    = 0,
  parameter int          FIX_X      = 0,
  parameter int          FIX_Y      = 0,
  parameter int          NUM_PKTS   = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_send,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_transmit,
  input  logic [FLIT_W-1:0] i_flit,
  input  logic              i_rec_req,
  output logic              o_rec_ack,
  output logic [CNT_W-1:0]  o_tx_pkt_cnt,
  output logic [CNT_W-1:0]  o_rx_flit_cnt,
  output logic [CNT_W-1:0]  o_rx_err_cnt,
  output logic              o_done
);

  localparam int SEQ_W  = FLIT_W - 18;
  localparam int SLOT_W = $clog2(INJ_PERIOD + 1);
  localparam logic [SLOT_W-1:0] SLOT_RELOAD = SLOT_W'(INJ_PERIOD - 1);
  localparam logic [3:0] OWN_X = 4'(XADDR);
  localparam logic [3:0] OWN_Y = 4'(YADDR);
  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;
  localparam logic [1:0] FIRST_T = (PKT_LEN == 1) ? T_SINGLE : T_HEAD;

  typedef enum logic [2:0] {IDLE, PICK, SEND, GAP, DONE} state_t;

  state_t            state;
  logic [15:0]       lfsr;
  logic [SLOT_W-1:0] slot;
  logic [7:0]        idx;
  logic [3:0]        dst_x, dst_y;
  logic              in_pkt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] t, input logic [3:0] x,
                                                input logic [3:0] y, input logic [CNT_W-1:0] n);
    return {t, x, y, OWN_X, OWN_Y, SEQ_W'(n)};
  endfunction

  // Destination selection for the current PICK cycle
  logic [3:0] ux, uy, pick_x, pick_y;
  logic       pick_ok, pick_skip;
  assign ux = lfsr[3:0];
  assign uy = lfsr[7:4];

  always_comb begin
    pick_x = ux;
    pick_y = uy;
    pick_ok = 1'b0;
    pick_skip = 1'b0;
    case (PATTERN)
      1: begin
        pick_x = OWN_Y;
        pick_y = OWN_X;
        if (XADDR == YADDR || YADDR >= COLS || XADDR >= ROWS) pick_skip = 1'b1;
        else pick_ok = 1'b1;
      end
      2: begin
        pick_x = 4'(FIX_X);
        pick_y = 4'(FIX_Y);
        if (FIX_X == XADDR && FIX_Y == YADDR) pick_skip = 1'b1;
        else pick_ok = 1'b1;
      end
      default: begin
        if (ROWS * COLS == 1) pick_skip = 1'b1;
        else if ({1'b0, ux} < 5'(COLS) && {1'b0, uy} < 5'(ROWS) && !(ux == OWN_X && uy == OWN_Y))
          pick_ok = 1'b1;
      end
    endcase
  end

  logic last_flit, last_pkt;
  logic [1:0] nxt_t;
  assign last_flit = (idx == 8'(PKT_LEN - 1));
  assign last_pkt  = (NUM_PKTS != 0) && (o_tx_pkt_cnt == CNT_W'(NUM_PKTS - 1));
  assign nxt_t     = (idx + 8'd1 == 8'(PKT_LEN - 1)) ? T_TAIL : T_BODY;

  // Sink side decode
  logic [1:0] rx_t;
  logic       rx_bad;
  logic       unused_rx;
  assign rx_t   = i_flit[FLIT_W-1:FLIT_W-2];
  assign rx_bad = (i_flit[FLIT_W-3:FLIT_W-6] != OWN_X) || (i_flit[FLIT_W-7:FLIT_W-10] != OWN_Y) ||
                  ((rx_t == T_HEAD || rx_t == T_SINGLE) && in_pkt) ||
                  ((rx_t == T_BODY || rx_t == T_TAIL) && !in_pkt);
  assign unused_rx = ^i_flit[FLIT_W-11:0];
  assign o_rec_ack = i_rec_req & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      slot          <= '0;
      idx           <= '0;
      dst_x         <= '0;
      dst_y         <= '0;
      in_pkt        <= 1'b0;
      o_flit        <= '0;
      o_transmit    <= 1'b0;
      o_tx_pkt_cnt  <= '0;
      o_rx_flit_cnt <= '0;
      o_rx_err_cnt  <= '0;
      o_done        <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (slot != '0) slot <= slot - 1'b1;
      case (state)
        IDLE: if (i_start) begin
          state <= PICK;
          slot  <= SLOT_RELOAD;
        end
        PICK: begin
          if (pick_ok) begin
            state      <= SEND;
            o_transmit <= 1'b1;
            o_flit     <= mk_flit(FIRST_T, pick_x, pick_y, o_tx_pkt_cnt);
            dst_x      <= pick_x;
            dst_y      <= pick_y;
            idx        <= '0;
          end else if (pick_skip) begin
            state <= GAP;
          end
        end
        SEND: if (i_send) begin
          if (last_flit) begin
            o_transmit   <= 1'b0;
            o_tx_pkt_cnt <= sat_inc(o_tx_pkt_cnt);
            if (last_pkt) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else if (slot == '0 && i_start) begin
              // slot already expired during a long packet: next pick follows the tail directly
              state <= PICK;
              slot  <= SLOT_RELOAD;
            end else begin
              state <= GAP;
            end
          end else begin
            idx    <= idx + 8'd1;
            o_flit <= mk_flit(nxt_t, dst_x, dst_y, o_tx_pkt_cnt);
          end
        end
        GAP: if (slot == '0 && i_start) begin
          state <= PICK;
          slot  <= SLOT_RELOAD;
        end
        DONE: ;
        default: state <= IDLE;
      endcase

      if (i_rec_req) begin
        o_rx_flit_cnt <= sat_inc(o_rx_flit_cnt);
        if (rx_bad) o_rx_err_cnt <= sat_inc(o_rx_err_cnt);
        if (rx_t == T_HEAD) in_pkt <= 1'b1;
        else if (rx_t == T_TAIL) in_pkt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_gen_param.sv
// Directed bench: RX framing table, TX framing/stall/reset sequences, pacing, transpose and uniform patterns.
module tb_noc_traffic_gen_param;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rst1 = 1'b1;
  logic start1 = 1'b0, start_all = 1'b0, send1 = 1'b1, send_all = 1'b1;
  logic [31:0] flit1 = '0, idle_flit = '0;
  logic req1 = 1'b0, idle_req = 1'b0;

  logic [31:0] f1, f3, f4a, f4b, f6;
  logic        tx1, tx3, tx4a, tx4b, tx6;
  logic        ack1, ack3, ack4a, ack4b, ack6;
  logic        done1, done3, done4a, done4b, done6;
  logic [31:0] tc1, rf1, re1, tc3, rf3, re3, tc4a, rf4a, re4a, tc4b, rf4b, re4b, tc6, rf6, re6;

  noc_traffic_gen_param #(.PKT_LEN(4), .INJ_PERIOD(16), .PATTERN(2), .FIX_X(1), .FIX_Y(0)) u1 (
    .clk(clk), .reset(rst1), .i_start(start1), .i_send(send1), .o_flit(f1), .o_transmit(tx1),
    .i_flit(flit1), .i_rec_req(req1), .o_rec_ack(ack1), .o_tx_pkt_cnt(tc1),
    .o_rx_flit_cnt(rf1), .o_rx_err_cnt(re1), .o_done(done1));

  noc_traffic_gen_param #(.PKT_LEN(4), .INJ_PERIOD(2), .PATTERN(2), .FIX_X(1), .FIX_Y(0), .NUM_PKTS(3)) u3 (
    .clk(clk), .reset(rst), .i_start(start_all), .i_send(send_all), .o_flit(f3), .o_transmit(tx3),
    .i_flit(idle_flit), .i_rec_req(idle_req), .o_rec_ack(ack3), .o_tx_pkt_cnt(tc3),
    .o_rx_flit_cnt(rf3), .o_rx_err_cnt(re3), .o_done(done3));

  noc_traffic_gen_param #(.XADDR(2), .YADDR(2), .PATTERN(1)) u4a (
    .clk(clk), .reset(rst), .i_start(start_all), .i_send(send_all), .o_flit(f4a), .o_transmit(tx4a),
    .i_flit(idle_flit), .i_rec_req(idle_req), .o_rec_ack(ack4a), .o_tx_pkt_cnt(tc4a),
    .o_rx_flit_cnt(rf4a), .o_rx_err_cnt(re4a), .o_done(done4a));

  noc_traffic_gen_param #(.XADDR(1), .YADDR(2), .PATTERN(1), .INJ_PERIOD(8)) u4b (
    .clk(clk), .reset(rst), .i_start(start_all), .i_send(send_all), .o_flit(f4b), .o_transmit(tx4b),
    .i_flit(idle_flit), .i_rec_req(idle_req), .o_rec_ack(ack4b), .o_tx_pkt_cnt(tc4b),
    .o_rx_flit_cnt(rf4b), .o_rx_err_cnt(re4b), .o_done(done4b));

  noc_traffic_gen_param #(.XADDR(1), .YADDR(1), .PATTERN(0), .PKT_LEN(1), .INJ_PERIOD(1), .NUM_PKTS(1000)) u6 (
    .clk(clk), .reset(rst), .i_start(start_all), .i_send(send_all), .o_flit(f6), .o_transmit(tx6),
    .i_flit(idle_flit), .i_rec_req(idle_req), .o_rec_ack(ack6), .o_tx_pkt_cnt(tc6),
    .o_rx_flit_cnt(rf6), .o_rx_err_cnt(re6), .o_done(done6));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkf(input logic [1:0] t, input logic [3:0] dx, input logic [3:0] dy,
                                      input logic [13:0] seq);
    return {t, dx, dy, 4'd0, 4'd0, seq};
  endfunction

  function automatic logic [1:0] exp_t(input int k);
    return (k == 0) ? 2'b00 : (k == 3) ? 2'b10 : 2'b01;
  endfunction

  // Background observers for the free-running instances, sampled once per tick
  logic u3_prev = 1'b0, u4a_seen = 1'b0;
  int   u3_run = 0, u3_gap = 0, u3_pkts = 0;

  task tick;
    @(posedge clk);
    #1;
    if (tx3) begin
      if (!u3_prev && u3_pkts > 0) chk("t3_gap", u3_gap, 1);
      u3_run++;
      u3_gap = 0;
    end else begin
      if (u3_prev) begin
        chk("t3_pkt_len", u3_run, 4);
        u3_pkts++;
        u3_run = 0;
        chk("t3_done_at_tail", done3, (u3_pkts == 3) ? 1 : 0);
      end
      u3_gap++;
    end
    u3_prev = tx3;
    if (tx4a) u4a_seen = 1'b1;
    if (tx4b) chk("t4_dst", f4b[29:22], 8'h21);
    if (tx6) begin
      checks++;
      if (f6[31:30] != 2'b11 || f6[29:26] >= 4 || f6[25:22] >= 4 || (f6[29:26] == 1 && f6[25:22] == 1)) begin
        errors++;
        $display("FAIL t6_dst actual type=%0d x=%0d y=%0d expected SINGLE in-range not (1,1)",
                 f6[31:30], f6[29:26], f6[25:22]);
      end
    end
  endtask

  typedef struct {
    logic [31:0] flit;
    logic        req;
    int          exp_flits;
    int          exp_errs;
  } rxv_t;
  rxv_t tbl [13];
  logic pat [10];

  initial begin
    logic [31:0] held;
    bit          stalled;
    int          n, nrx;

    tbl[0]  = '{mkf(2'b00, 4'd0, 4'd0, 14'd0), 1'b1, 1, 0};   // HEAD own
    tbl[1]  = '{mkf(2'b10, 4'd0, 4'd0, 14'd0), 1'b1, 2, 0};   // TAIL own
    tbl[2]  = '{mkf(2'b01, 4'd0, 4'd0, 14'd0), 1'b1, 3, 1};   // BODY outside packet
    tbl[3]  = '{mkf(2'b00, 4'd1, 4'd0, 14'd0), 1'b1, 4, 2};   // HEAD wrong dst
    tbl[4]  = '{mkf(2'b10, 4'd0, 4'd0, 14'd0), 1'b0, 4, 2};   // not valid
    tbl[5]  = '{mkf(2'b00, 4'd0, 4'd0, 14'd0), 1'b1, 5, 3};   // HEAD inside packet
    tbl[6]  = '{mkf(2'b01, 4'd0, 4'd0, 14'd0), 1'b1, 6, 3};   // BODY after restart
    tbl[7]  = '{mkf(2'b10, 4'd0, 4'd2, 14'd0), 1'b1, 7, 4};   // TAIL wrong dst
    tbl[8]  = '{mkf(2'b11, 4'd0, 4'd0, 14'd0), 1'b1, 8, 4};   // SINGLE own
    tbl[9]  = '{mkf(2'b10, 4'd0, 4'd0, 14'd0), 1'b1, 9, 5};   // TAIL outside packet
    tbl[10] = '{mkf(2'b11, 4'd3, 4'd3, 14'd0), 1'b1, 10, 6};  // SINGLE wrong dst, one error
    tbl[11] = '{mkf(2'b00, 4'd0, 4'd0, 14'd0), 1'b1, 11, 6};  // HEAD own
    tbl[12] = '{mkf(2'b11, 4'd0, 4'd0, 14'd0), 1'b1, 12, 7};  // SINGLE inside packet
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state, with a valid ejected flit present
    req1 = 1'b1;
    tick; tick;
    chk("rst_transmit", tx1, 0);
    chk("rst_flit", f1, 0);
    chk("rst_ack", ack1, 0);
    chk("rst_counts", {tc1, rf1 | re1}, 0);
    chk("rst_done", done1, 0);
    req1 = 1'b0;
    rst = 1'b0;
    rst1 = 1'b0;
    start_all = 1'b1;

    // RX framing and destination checks
    for (int i = 0; i < 13; i++) begin
      flit1 = tbl[i].flit;
      req1 = tbl[i].req;
      #1;
      chk($sformatf("rx_ack[%0d]", i), ack1, tbl[i].req);
      tick;
      chk($sformatf("rx_flits[%0d]", i), rf1, tbl[i].exp_flits);
      chk($sformatf("rx_errs[%0d]", i), re1, tbl[i].exp_errs);
    end
    req1 = 1'b0;
    chk("rx_no_tx_while_idle", tx1, 0);

    // Fixed destination packet, router always ready
    start1 = 1'b1;
    n = 0;
    while (!tx1 && n < 20) begin tick; n++; end
    chk("t1_started", tx1, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_flit[%0d]", k), f1, mkf(exp_t(k), 4'd1, 4'd0, 14'd0));
      chk($sformatf("t1_tx[%0d]", k), tx1, 1);
      tick;
    end
    chk("t1_drop", tx1, 0);
    chk("t1_pkt_cnt", tc1, 1);

    // Second packet with a 3-cycle stall on BODY; i_start dropped once it begins
    n = 0;
    while (!tx1 && n < 40) begin tick; n++; end
    chk("t2_started", tx1, 1);
    start1 = 1'b0;
    stalled = 1'b0;
    held = '0;
    nrx = 0;
    for (int j = 0; j < 10; j++) begin
      send1 = pat[j];
      if (stalled) chk("t2_hold_valid", tx1, 1);
      if (tx1) begin
        if (stalled) chk("t2_hold_flit", f1, held);
        if (send1) begin
          chk($sformatf("t2_flit[%0d]", nrx), f1, mkf(exp_t(nrx), 4'd1, 4'd0, 14'd1));
          nrx++;
          stalled = 1'b0;
        end else begin
          held = f1;
          stalled = 1'b1;
        end
      end else stalled = 1'b0;
      tick;
    end
    send1 = 1'b1;
    chk("t2_flits_delivered", nrx, 4);
    n = 0;
    for (int j = 0; j < 30; j++) begin
      if (tx1) n++;
      tick;
    end
    chk("t2_hold_after_stop", n, 0);
    chk("t2_pkt_cnt", tc1, 2);

    // Reset in the middle of a packet
    start1 = 1'b1;
    n = 0;
    while (!tx1 && n < 30) begin tick; n++; end
    chk("t6_started", tx1, 1);
    tick;
    chk("t6_body", f1, mkf(2'b01, 4'd1, 4'd0, 14'd2));
    rst1 = 1'b1;
    req1 = 1'b1;
    tick;
    chk("t6_rst_transmit", tx1, 0);
    chk("t6_rst_flit", f1, 0);
    chk("t6_rst_ack", ack1, 0);
    chk("t6_rst_counts", {tc1, rf1 | re1}, 0);
    chk("t6_rst_done", done1, 0);
    rst1 = 1'b0;
    req1 = 1'b0;
    start1 = 1'b0;

    // Let the uniform-pattern node finish its packet budget
    n = 0;
    while (!done6 && n < 70000) begin tick; n++; end
    chk("t6_done", done6, 1);
    chk("t6_pkt_cnt", tc6, 1000);
    chk("t3_pkts", u3_pkts, 3);
    chk("t3_pkt_cnt", tc3, 3);
    chk("t3_done", done3, 1);
    chk("t4_diag_never_tx", u4a_seen, 0);
    chk("t4_diag_cnt", tc4a, 0);
    chk("t4_sent", tc4b != 0, 1);
    chk("t4_no_done_unlimited", done4b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
